pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory accesses through a ready handshake with a timeout watchdog. It also keeps stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus.
// Groups the hazard sources coming from the ID/EX/MEM stages with the
// register enables, bubble flushes and status returned by the controller.
//   master : pipeline side (drives hazard sources, consumes enables/flushes)
//   slave  : hazard controller
interface pipeline_hazard_ctrl_if;
  logic [4:0]  rs1_ID;
  logic [4:0]  rs2_ID;
  logic        rs1_use_ID;
  logic        rs2_use_ID;
  logic        Mem2Reg_EX;
  logic        RegWrite_EX;
  logic [4:0]  waddr_EX;
  logic        branch_taken_EX;
  logic        mem_req_MEM;
  logic        mem_ready;

  logic        PC_EN;
  logic        IF_ID_EN;
  logic        ID_EX_EN;
  logic        EX_MEM_EN;
  logic        MEM_WB_EN;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        MEM_WB_flush;
  logic        mem_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output rs1_ID, rs2_ID, rs1_use_ID, rs2_use_ID, Mem2Reg_EX, RegWrite_EX,
           waddr_EX, branch_taken_EX, mem_req_MEM, mem_ready,
    input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
           IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_use_ID, rs2_use_ID, Mem2Reg_EX, RegWrite_EX,
           waddr_EX, branch_taken_EX, mem_req_MEM, mem_ready,
    output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
           IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Resolves data-memory wait states (with timeout watchdog), taken-branch
// redirects and load-use hazards; keeps stall and redirect counters.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : pipeline_hazard_ctrl_if.slave (hazard sources in, enables,
//          flushes, mem_err and counters out)
// Enables and flushes are combinational; state, counters and mem_err are
// registered.
//
// state | meaning
// RUN   | no outstanding multi-cycle memory access
// WAIT  | pipeline frozen, waiting for mem_ready or timeout
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [0:0]  r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_err;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  logic w_in_wait;
  logic w_timeout;
  logic w_freeze;
  logic w_drop;
  logic w_redirect;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;

  logic w_pc_en;
  logic w_if_id_en;
  logic w_id_ex_en;
  logic w_ex_mem_en;
  logic w_mem_wb_en;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_mem_wb_flush;

  assign w_in_wait = (r_state == ST_WAIT);
  assign w_timeout = w_in_wait & (r_wait_cnt == TO_LAST);
  assign w_freeze  = (~w_in_wait & bus.mem_req_MEM & ~bus.mem_ready) |
                     (w_in_wait & ~bus.mem_ready & ~w_timeout);
  // Timed-out access is released but its write-back is squashed.
  assign w_drop    = w_timeout & ~bus.mem_ready;

  assign w_redirect = bus.branch_taken_EX;
  assign w_rs1_hit  = bus.rs1_use_ID & (bus.rs1_ID == bus.waddr_EX);
  assign w_rs2_hit  = bus.rs2_use_ID & (bus.rs2_ID == bus.waddr_EX);
  assign w_load_use = bus.Mem2Reg_EX & bus.RegWrite_EX & (bus.waddr_EX != 5'd0) &
                      (w_rs1_hit | w_rs2_hit);

  always_comb begin
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_id_ex_en     = 1'b1;
    w_ex_mem_en    = 1'b1;
    w_mem_wb_en    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_mem_wb_flush = 1'b0;
    if (!rst) begin
      if (w_freeze) begin
        // Hold everything up to MEM; write-back sees bubbles meanwhile.
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_id_ex_en     = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_flush = 1'b1;
      end else begin
        w_mem_wb_flush = w_drop;
        if (w_redirect) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          w_pc_en       = 1'b0;
          w_if_id_en    = 1'b0;
          w_id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 8'd0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (!w_pc_en) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redirect && !w_freeze) r_flush_cnt <= r_flush_cnt + 32'd1;

      case (r_state)
        ST_RUN: begin
          if (bus.mem_req_MEM && !bus.mem_ready) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        default: begin
          if (bus.mem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end else if (w_timeout) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.PC_EN        = w_pc_en;
  assign bus.IF_ID_EN     = w_if_id_en;
  assign bus.ID_EX_EN     = w_id_ex_en;
  assign bus.EX_MEM_EN    = w_ex_mem_en;
  assign bus.MEM_WB_EN    = w_mem_wb_en;
  assign bus.IF_ID_flush  = w_if_id_flush;
  assign bus.ID_EX_flush  = w_id_ex_flush;
  assign bus.MEM_WB_flush = w_mem_wb_flush;
  assign bus.mem_err      = r_mem_err;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Two instances share stimulus: one with
// the default MEM_TIMEOUT=16 and one with MEM_TIMEOUT=4 for watchdog cases.
// Output vector bit order: {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
//                           IF_ID_flush, ID_EX_flush, MEM_WB_flush}
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus16 ();
  pipeline_hazard_ctrl_if bus4 ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  localparam logic [7:0] NORM   = 8'b11111_000;
  localparam logic [7:0] LU     = 8'b00111_010;
  localparam logic [7:0] RED    = 8'b11111_110;
  localparam logic [7:0] FRZ    = 8'b00001_001;
  localparam logic [7:0] REL_TO = 8'b11111_001;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2, m2r, rw;
    logic [4:0] wa;
    logic       br, mq, my;
    logic [7:0] e16, e4;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[20];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_stall16 = 0, m_flush16 = 0, m_stall4 = 0, m_flush4 = 0;
  logic        m_err16 = 0, m_err4 = 0;

  function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic m2r, logic rw, logic [4:0] wa, logic br, logic mq,
                              logic my, logic [7:0] e16, logic [7:0] e4);
    vec_t v;
    v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.m2r = m2r; v.rw = rw;
    v.wa = wa; v.br = br; v.mq = mq; v.my = my; v.e16 = e16; v.e4 = e4;
    return v;
  endfunction

  function automatic vec_t mem(logic mq, logic my, logic [7:0] e16, logic [7:0] e4);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, mq, my, e16, e4);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(vec_t v);
    rst = v.rst;
    bus16.rs1_ID = v.rs1; bus16.rs2_ID = v.rs2; bus16.rs1_use_ID = v.u1; bus16.rs2_use_ID = v.u2;
    bus16.Mem2Reg_EX = v.m2r; bus16.RegWrite_EX = v.rw; bus16.waddr_EX = v.wa;
    bus16.branch_taken_EX = v.br; bus16.mem_req_MEM = v.mq; bus16.mem_ready = v.my;
    bus4.rs1_ID = v.rs1; bus4.rs2_ID = v.rs2; bus4.rs1_use_ID = v.u1; bus4.rs2_use_ID = v.u2;
    bus4.Mem2Reg_EX = v.m2r; bus4.RegWrite_EX = v.rw; bus4.waddr_EX = v.wa;
    bus4.branch_taken_EX = v.br; bus4.mem_req_MEM = v.mq; bus4.mem_ready = v.my;
  endtask

  task automatic run_vec(vec_t v, string tag);
    vec_t e;
    @(posedge clk);
    #1;
    set_in(v);
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    check({tag, ".out16"}, {24'd0, bus16.PC_EN, bus16.IF_ID_EN, bus16.ID_EX_EN, bus16.EX_MEM_EN,
          bus16.MEM_WB_EN, bus16.IF_ID_flush, bus16.ID_EX_flush, bus16.MEM_WB_flush}, {24'd0, e.e16});
    check({tag, ".out4"}, {24'd0, bus4.PC_EN, bus4.IF_ID_EN, bus4.ID_EX_EN, bus4.EX_MEM_EN,
          bus4.MEM_WB_EN, bus4.IF_ID_flush, bus4.ID_EX_flush, bus4.MEM_WB_flush}, {24'd0, e.e4});
    // Registered status reflects all cycles before this one.
    check({tag, ".stall16"}, bus16.stall_cnt, m_stall16);
    check({tag, ".flush16"}, bus16.flush_cnt, m_flush16);
    check({tag, ".err16"}, {31'd0, bus16.mem_err}, {31'd0, m_err16});
    check({tag, ".stall4"}, bus4.stall_cnt, m_stall4);
    check({tag, ".flush4"}, bus4.flush_cnt, m_flush4);
    check({tag, ".err4"}, {31'd0, bus4.mem_err}, {31'd0, m_err4});
    if (e.rst) begin
      m_stall16 = 0; m_flush16 = 0; m_err16 = 0;
      m_stall4 = 0; m_flush4 = 0; m_err4 = 0;
    end else begin
      if (!e.e16[7]) m_stall16 += 1;
      if (e.e16[2])  m_flush16 += 1;
      if (e.e16 == REL_TO) m_err16 = 1;
      if (!e.e4[7]) m_stall4 += 1;
      if (e.e4[2])  m_flush4 += 1;
      if (e.e4 == REL_TO) m_err4 = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    set_in(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, NORM));
    repeat (2) @(posedge clk);

    //            rst rs1 rs2 u1 u2 m2r rw wa br mq my
    tbl[0]  = mk(1,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);
    tbl[1]  = mk(0,  1,  2, 1, 1, 0, 1, 3, 0, 0, 0, NORM, NORM);
    tbl[2]  = mk(0,  5,  6, 1, 1, 1, 1, 5, 0, 0, 0, LU,   LU);
    tbl[3]  = mk(0,  5,  6, 1, 1, 0, 0, 0, 0, 0, 0, NORM, NORM);
    tbl[4]  = mk(0,  1,  7, 1, 1, 1, 1, 7, 0, 0, 0, LU,   LU);
    tbl[5]  = mk(0,  7,  0, 0, 0, 1, 1, 7, 0, 0, 0, NORM, NORM);
    tbl[6]  = mk(0,  0,  0, 1, 0, 1, 1, 0, 0, 0, 0, NORM, NORM);
    tbl[7]  = mk(0,  9,  0, 1, 0, 0, 1, 9, 0, 0, 0, NORM, NORM);
    tbl[8]  = mk(0,  4,  0, 1, 0, 1, 1, 4, 1, 0, 0, RED,  RED);
    tbl[9]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);
    tbl[10] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, NORM);
    tbl[11] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  FRZ);
    tbl[12] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  FRZ);
    tbl[13] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  FRZ);
    tbl[14] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, NORM);
    tbl[15] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  FRZ);
    tbl[16] = mk(0,  8,  0, 1, 0, 1, 1, 8, 0, 1, 1, LU,   LU);
    tbl[17] = mk(0,  0,  0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  FRZ);
    tbl[18] = mk(0,  0,  0, 0, 0, 0, 0, 0, 1, 1, 1, RED,  RED);
    tbl[19] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, NORM);

    for (int i = 0; i < 20; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Watchdog: MEM_TIMEOUT=4 instance drops the access after 3 freezes.
    run_vec(mem(1, 0, FRZ, FRZ),    "to0");
    run_vec(mem(1, 0, FRZ, FRZ),    "to1");
    run_vec(mem(1, 0, FRZ, FRZ),    "to2");
    run_vec(mem(1, 0, FRZ, REL_TO), "to3");
    run_vec(mem(0, 1, NORM, NORM),  "to4");
    run_vec(mem(0, 0, NORM, NORM),  "to5");
    run_vec(mem(0, 0, NORM, NORM),  "to6");

    // Reset in the middle of a wait abandons it; a fresh access gets a full window.
    run_vec(mem(1, 0, FRZ, FRZ), "rw0");
    run_vec(mem(1, 0, FRZ, FRZ), "rw1");
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NORM, NORM), "rw_rst");
    run_vec(mem(0, 0, NORM, NORM), "rw2");
    run_vec(mem(1, 0, FRZ, FRZ),    "rw3");
    run_vec(mem(1, 0, FRZ, FRZ),    "rw4");
    run_vec(mem(1, 0, FRZ, FRZ),    "rw5");
    run_vec(mem(1, 0, FRZ, REL_TO), "rw6");
    run_vec(mem(0, 1, NORM, NORM),  "rw7");
    run_vec(mem(0, 0, NORM, NORM),  "rw8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
